// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the parametrised serial-bus arbiter:
//   arb_state_t - arbiter FSM states
//   ARB_FIXED   - fixed-priority arbitration (lowest index wins)
//   ARB_RR      - round-robin arbitration
//   sel_width() - index width for n items (never below 1 bit)
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_ADDR      = 3'd2,
        ST_DECODE    = 3'd3,
        ST_CONNECTED = 3'd4,
        ST_SPLIT     = 3'd5,
        ST_CLEAN     = 3'd6
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // A one-item index still needs a 1-bit vector to stay a legal type.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational request picker.
//   MODE = ARB_FIXED : lowest set request wins, ptr is ignored.
//   MODE = ARB_RR    : search starts at ptr+1 and wraps around.
// Ports:
//   req - request vector (N bits)
//   ptr - last winner (round-robin pointer, held by the parent)
//   gnt - one-hot winner, all zero when no request
//   idx - binary index of the winner, zero when no request
// -----------------------------------------------------------------------------
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_FIXED,
    localparam int IW  = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (MODE == ARB_RR) ? ((int'(ptr) + 1 + k) % N) : k;
            if (!found && req[IW'(pos)]) begin
                found           = 1'b1;
                gnt[IW'(pos)]   = 1'b1;
                idx             = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// -----------------------------------------------------------------------------
// bus_arbiter_n
// Arbiter between NUM_MASTERS serial-bus masters and NUM_SLAVES slaves (the
// highest slave is the bus bridge). The granted master shifts in an
// ADDR_BITS-long address MSB first; its top bits select the slave, after
// which the owner's handshake signals are routed to that slave only.
// Split transactions are remembered per master and resumed with priority
// once the holding slave releases its split line.
//
// Optional build macro ARB_TIMEOUT_EN: bounds the CONNECTED tenure to
// TIMEOUT_CYCLES cycles and adds the sticky timeout_flag output.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   m_breq / m_bgrant         per-master request / one-hot grant
//   m_mode, m_wr_bus,
//   m_master_valid,
//   m_master_ready            master-side inputs from each master
//   m_rd_bus, m_slave_ready,
//   m_slave_valid, m_ack,
//   m_split                   master-side outputs to each master
//   s_mode, s_wr_bus,
//   s_master_valid,
//   s_master_ready            owner's signals copied to the selected slave
//   s_rd_bus, s_slave_ready,
//   s_slave_valid, s_split    slave responses
//   timeout_flag              sticky tenure timeout (ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_BITS      = 12,
    parameter int ARB_MODE       = ARB_FIXED,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_breq,
    output logic [NUM_MASTERS-1:0] m_bgrant,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    output logic [NUM_MASTERS-1:0] m_rd_bus,
    input  logic [NUM_MASTERS-1:0] m_master_valid,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    input  logic [NUM_MASTERS-1:0] m_master_ready,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic [NUM_MASTERS-1:0] m_ack,
    output logic [NUM_MASTERS-1:0] m_split,
    output logic [NUM_SLAVES-1:0]  s_mode,
    output logic [NUM_SLAVES-1:0]  s_wr_bus,
    output logic [NUM_SLAVES-1:0]  s_master_valid,
    output logic [NUM_SLAVES-1:0]  s_master_ready,
    input  logic [NUM_SLAVES-1:0]  s_rd_bus,
    input  logic [NUM_SLAVES-1:0]  s_slave_ready,
    input  logic [NUM_SLAVES-1:0]  s_slave_valid,
    input  logic [NUM_SLAVES-1:0]  s_split
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                   timeout_flag
`endif
);

    localparam int OW = sel_width(NUM_MASTERS);
    localparam int SW = sel_width(NUM_SLAVES);
    localparam int CW = $clog2(ADDR_BITS + 1);
    localparam logic [SW:0] NS_W = (SW + 1)'(NUM_SLAVES);

    arb_state_t             state_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          rr_ptr_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [CW-1:0]          count_q;
    logic [SW-1:0]          sel_q;
    logic [NUM_MASTERS-1:0] split_pend_q;
    logic [SW-1:0]          split_slv_q [NUM_MASTERS];

    // ---------------------------------------------------------------------
    // Request selection
    // ---------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] req_gnt;
    logic [OW-1:0]          req_idx;
    logic                   req_any;
    logic [NUM_MASTERS-1:0] resume_req;
    logic [NUM_MASTERS-1:0] resume_gnt;
    logic [OW-1:0]          resume_idx;
    logic                   resume_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resume
            // A parked split may resume once its slave drops s_split.
            assign resume_req[gi] = split_pend_q[gi] & ~s_split[split_slv_q[gi]];
        end
    endgenerate

    // Masters with a parked split must not re-enter through GRANT.
    assign eligible = m_breq & ~split_pend_q;

    rr_picker #(
        .N    (NUM_MASTERS),
        .MODE (ARB_MODE)
    ) u_req_pick (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (req_gnt),
        .idx (req_idx)
    );

    // Resumes are always taken lowest index first.
    rr_picker #(
        .N    (NUM_MASTERS),
        .MODE (ARB_FIXED)
    ) u_resume_pick (
        .req (resume_req),
        .ptr (rr_ptr_q),
        .gnt (resume_gnt),
        .idx (resume_idx)
    );

    assign req_any    = |req_gnt;
    assign resume_any = |resume_gnt;

    // ---------------------------------------------------------------------
    // Owner view and address decode
    // ---------------------------------------------------------------------
    logic          owner_breq;
    logic          owner_valid;
    logic          owner_wr;
    logic [SW-1:0] sel_d;
    logic          sel_ok;
    logic          timeout_hit;

    assign owner_breq  = m_breq[owner_q];
    assign owner_valid = m_master_valid[owner_q];
    assign owner_wr    = m_wr_bus[owner_q];
    assign sel_d       = addr_q[ADDR_BITS-1 -: SW];
    // Non-power-of-two slave counts leave unused codes that must NACK.
    assign sel_ok      = ({1'b0, sel_d} < NS_W);

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tenure_q;
    logic          timeout_flag_q;
    assign timeout_hit  = (tenure_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_flag_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Arbiter FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            sel_q        <= '0;
            split_pend_q <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                split_slv_q[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            tenure_q       <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            tenure_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (resume_any) begin
                        owner_q                  <= resume_idx;
                        sel_q                    <= split_slv_q[resume_idx];
                        split_pend_q[resume_idx] <= 1'b0;
                        state_q                  <= ST_CONNECTED;
                    end else if (req_any) begin
                        owner_q <= req_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_breq) begin
                        state_q <= ST_IDLE;
                    end else if (owner_valid) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!owner_breq) begin
                        state_q <= ST_CLEAN;
                    end else if (owner_valid) begin
                        addr_q  <= {addr_q[ADDR_BITS-2:0], owner_wr};
                        count_q <= count_q + CW'(1);
                        if (count_q == CW'(ADDR_BITS - 1)) begin
                            state_q <= ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    count_q <= '0;
                    sel_q   <= sel_d;
                    state_q <= sel_ok ? ST_CONNECTED : ST_CLEAN;
                end
                ST_CONNECTED: begin
`ifdef ARB_TIMEOUT_EN
                    tenure_q <= tenure_q + TW'(1);
`endif
                    // A dropped request wins over a split raised in the same cycle.
                    if (!owner_breq) begin
                        state_q <= ST_CLEAN;
                    end else if (timeout_hit) begin
                        state_q <= ST_CLEAN;
`ifdef ARB_TIMEOUT_EN
                        timeout_flag_q <= 1'b1;
`endif
                    end else if (s_split[sel_q]) begin
                        state_q <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    split_pend_q[owner_q] <= 1'b1;
                    split_slv_q[owner_q]  <= sel_q;
                    addr_q                <= '0;
                    count_q               <= '0;
                    state_q               <= ST_IDLE;
                end
                ST_CLEAN: begin
                    addr_q   <= '0;
                    count_q  <= '0;
                    rr_ptr_q <= owner_q;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Signal routing: only the owner and the decoded slave see non-zero values
    // ---------------------------------------------------------------------
    logic grant_st;
    logic addr_st;
    logic conn_st;

    assign grant_st = (state_q == ST_GRANT) || (state_q == ST_ADDR) ||
                      (state_q == ST_DECODE) || (state_q == ST_CONNECTED);
    assign addr_st  = (state_q == ST_ADDR);
    assign conn_st  = (state_q == ST_CONNECTED);

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic own;
            assign own                = (owner_q == OW'(gi));
            assign m_bgrant[gi]       = own & grant_st;
            assign m_ack[gi]          = own & conn_st;
            // During ADDR the arbiter itself is the ready party.
            assign m_slave_ready[gi]  = own & (addr_st | (conn_st & s_slave_ready[sel_q]));
            assign m_rd_bus[gi]       = own & conn_st & s_rd_bus[sel_q];
            assign m_slave_valid[gi]  = own & conn_st & s_slave_valid[sel_q];
            assign m_split[gi]        = split_pend_q[gi] & s_split[split_slv_q[gi]];
        end

        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            logic hit;
            assign hit                = conn_st & (sel_q == SW'(gi));
            assign s_mode[gi]         = hit & m_mode[owner_q];
            assign s_wr_bus[gi]       = hit & m_wr_bus[owner_q];
            assign s_master_valid[gi] = hit & m_master_valid[owner_q];
            assign s_master_ready[gi] = hit & m_master_ready[owner_q];
        end
    endgenerate

endmodule

// File: tb/tb_bus_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_n
// Two arbiters share the master-side stimulus:
//   u_rr : 4 masters, 4 slaves, round-robin
//   u_fp : 4 masters, 5 slaves, fixed priority (has unused slave codes)
// Directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_n;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] m_breq, m_mode, m_wr_bus, m_master_valid, m_master_ready;
    logic [4:0] s_rd_bus, s_slave_ready, s_slave_valid, s_split;

    logic [3:0] rr_bgrant, rr_rd_bus, rr_slave_ready, rr_slave_valid, rr_ack, rr_split;
    logic [3:0] rr_s_mode, rr_s_wr_bus, rr_s_master_valid, rr_s_master_ready;
    logic [3:0] fp_bgrant, fp_rd_bus, fp_slave_ready, fp_slave_valid, fp_ack, fp_split;
    logic [4:0] fp_s_mode, fp_s_wr_bus, fp_s_master_valid, fp_s_master_ready;
`ifdef ARB_TIMEOUT_EN
    logic rr_tflag, fp_tflag;
`endif

    int checks   = 0;
    int failures = 0;

    logic mon_en      = 1'b0;
    logic fp_smv_seen = 1'b0;
    logic fp_ack_seen = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_n #(
        .NUM_MASTERS(4), .NUM_SLAVES(4), .ADDR_BITS(12), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
    ) u_rr (
        .clk(clk), .rstn(rstn),
        .m_breq(m_breq), .m_bgrant(rr_bgrant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
        .m_rd_bus(rr_rd_bus), .m_master_valid(m_master_valid), .m_slave_ready(rr_slave_ready),
        .m_master_ready(m_master_ready), .m_slave_valid(rr_slave_valid), .m_ack(rr_ack),
        .m_split(rr_split),
        .s_mode(rr_s_mode), .s_wr_bus(rr_s_wr_bus), .s_master_valid(rr_s_master_valid),
        .s_master_ready(rr_s_master_ready),
        .s_rd_bus(s_rd_bus[3:0]), .s_slave_ready(s_slave_ready[3:0]),
        .s_slave_valid(s_slave_valid[3:0]), .s_split(s_split[3:0])
`ifdef ARB_TIMEOUT_EN
        , .timeout_flag(rr_tflag)
`endif
    );

    bus_arbiter_n #(
        .NUM_MASTERS(4), .NUM_SLAVES(5), .ADDR_BITS(12), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
    ) u_fp (
        .clk(clk), .rstn(rstn),
        .m_breq(m_breq), .m_bgrant(fp_bgrant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
        .m_rd_bus(fp_rd_bus), .m_master_valid(m_master_valid), .m_slave_ready(fp_slave_ready),
        .m_master_ready(m_master_ready), .m_slave_valid(fp_slave_valid), .m_ack(fp_ack),
        .m_split(fp_split),
        .s_mode(fp_s_mode), .s_wr_bus(fp_s_wr_bus), .s_master_valid(fp_s_master_valid),
        .s_master_ready(fp_s_master_ready),
        .s_rd_bus(s_rd_bus), .s_slave_ready(s_slave_ready),
        .s_slave_valid(s_slave_valid), .s_split(s_split)
`ifdef ARB_TIMEOUT_EN
        , .timeout_flag(fp_tflag)
`endif
    );

    // Watches the fixed-priority instance during the invalid-address scenario.
    always @(negedge clk) begin
        if (mon_en) begin
            if (|fp_s_master_valid) fp_smv_seen = 1'b1;
            if (|fp_ack)            fp_ack_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_breq = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
        s_rd_bus = '0; s_slave_ready = '0; s_slave_valid = '0; s_split = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Called in GRANT; returns in the cycle after DECODE (CONNECTED or CLEAN).
    task automatic send_addr(input logic [1:0] m, input logic [11:0] a);
        logic [11:0] sh;
        sh = a;
        m_master_valid[m] = 1'b1;
        m_wr_bus[m]       = sh[11];
        tick();                               // GRANT -> ADDR
        repeat (12) begin
            m_wr_bus[m] = sh[11];
            tick();
            sh = {sh[10:0], 1'b0};
        end                                   // last bit -> DECODE
        m_master_valid[m] = 1'b0;
        m_wr_bus[m]       = 1'b0;
        tick();                               // DECODE -> CONNECTED/CLEAN
    endtask

    // One complete tenure; re-requests at once and returns in the next GRANT.
    task automatic tenure(input logic [1:0] m);
        send_addr(m, 12'h400);
        m_breq[m] = 1'b0;
        tick();                               // CLEAN
        m_breq[m] = 1'b1;
        tick();                               // IDLE
        tick();                               // GRANT for the next winner
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // ---------------- reset state ----------------
        rstn = 1'b0;
        clear_inputs();
        m_breq = 4'b1111;
        tick();
        tick();
        check("reset_rr_bgrant", 32'(rr_bgrant), 32'h0);
        check("reset_fp_bgrant", 32'(fp_bgrant), 32'h0);
        check("reset_rr_ack", 32'(rr_ack), 32'h0);
        check("reset_rr_slave_ready", 32'(rr_slave_ready), 32'h0);

        // ---------------- single request, master 2, addr 0x400 -> slave 1
        do_reset();
        m_breq[2] = 1'b1;
        tick();
        check("single_bgrant", 32'(rr_bgrant), 32'b0100);
        check("single_ack_in_grant", 32'(rr_ack), 32'h0);
        send_addr(2'd2, 12'h400);
        check("single_ack", 32'(rr_ack), 32'b0100);
        m_master_valid[2] = 1'b1;
        #1;
        check("single_s_mvalid_hi", 32'(rr_s_master_valid), 32'b0010);
        m_master_valid[2] = 1'b0;
        s_rd_bus[1] = 1'b1;
        #1;
        check("single_s_mvalid_lo", 32'(rr_s_master_valid), 32'h0);
        check("single_rd_bus", 32'(rr_rd_bus), 32'b0100);
        s_rd_bus[1] = 1'b0;
        m_breq[2] = 1'b0;
        tick();
        check("single_clean_bgrant", 32'(rr_bgrant), 32'h0);

        // ---------------- round-robin order 0,1,3,0 ----------------
        do_reset();
        m_breq = 4'b0001;
        tick();
        check("rr_grant_1st", 32'(rr_bgrant), 32'b0001);
        m_breq = 4'b1011;
        tenure(2'd0);
        check("rr_grant_2nd", 32'(rr_bgrant), 32'b0010);
        tenure(2'd1);
        check("rr_grant_3rd", 32'(rr_bgrant), 32'b1000);
        tenure(2'd3);
        check("rr_grant_4th", 32'(rr_bgrant), 32'b0001);

        // ---------------- fixed priority order 0,0,0 ----------------
        do_reset();
        m_breq = 4'b1011;
        tick();
        check("fp_grant_1st", 32'(fp_bgrant), 32'b0001);
        tenure(2'd0);
        check("fp_grant_2nd", 32'(fp_bgrant), 32'b0001);
        tenure(2'd0);
        check("fp_grant_3rd", 32'(fp_bgrant), 32'b0001);

        // ---------------- invalid address on 5-slave instance ----------------
        do_reset();
        fp_smv_seen = 1'b0;
        fp_ack_seen = 1'b0;
        mon_en = 1'b1;
        m_breq = 4'b0001;
        tick();
        send_addr(2'd0, 12'hC00);
        check("nack_ack_in_clean", 32'(fp_ack), 32'h0);
        check("nack_bgrant_in_clean", 32'(fp_bgrant), 32'h0);
        m_master_valid[0] = 1'b1;
        tick();
        check("nack_bgrant_in_idle", 32'(fp_bgrant), 32'h0);
        tick();
        check("nack_regrant", 32'(fp_bgrant), 32'b0001);
        mon_en = 1'b0;
        check("nack_no_s_mvalid", 32'(fp_smv_seen), 32'h0);
        check("nack_no_ack", 32'(fp_ack_seen), 32'h0);

        // ---------------- split with concurrent requests ----------------
        do_reset();
        m_breq = 4'b0001;
        tick();
        send_addr(2'd0, 12'h800);             // slave 2
        check("split_ack_m0", 32'(rr_ack), 32'b0001);
        s_split[2] = 1'b1;
        tick();                               // SPLIT
        check("split_bgrant_removed", 32'(rr_bgrant), 32'h0);
        m_breq[1] = 1'b1;
        tick();                               // IDLE, split parked
        check("split_m_split", 32'(rr_split), 32'b0001);
        tick();                               // GRANT master 1
        check("split_grant_m1", 32'(rr_bgrant), 32'b0010);
        send_addr(2'd1, 12'h400);
        check("split_ack_m1", 32'(rr_ack), 32'b0010);
        m_breq[1] = 1'b0;
        tick();                               // CLEAN
        m_breq[3]  = 1'b1;
        s_split[2] = 1'b0;
        tick();                               // IDLE, resume pending
        check("split_released", 32'(rr_split), 32'h0);
        tick();                               // straight to CONNECTED
        check("resume_bgrant_m0", 32'(rr_bgrant), 32'b0001);
        check("resume_ack_m0", 32'(rr_ack), 32'b0001);
        m_master_valid[0] = 1'b1;
        #1;
        check("resume_route_slv2", 32'(rr_s_master_valid), 32'b0100);

        // ---------------- breq drop and split rise together ----------------
        do_reset();
        m_breq = 4'b0001;
        tick();
        send_addr(2'd0, 12'h800);
        m_breq[0]  = 1'b0;
        s_split[2] = 1'b1;
        tick();                               // must be CLEAN, not SPLIT
        tick();                               // IDLE
        check("simul_no_split_pend", 32'(rr_split), 32'h0);
        check("simul_no_grant", 32'(rr_bgrant), 32'h0);

        // ---------------- asynchronous reset during ADDR ----------------
        do_reset();
        m_breq = 4'b0001;
        tick();
        m_master_valid[0] = 1'b1;
        tick();                               // ADDR
        check("addr_slave_ready", 32'(rr_slave_ready), 32'b0001);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_slave_ready", 32'(rr_slave_ready), 32'h0);
        check("async_rst_bgrant", 32'(rr_bgrant), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // ---------------- tenure timeout ----------------
        do_reset();
        m_breq = 4'b0001;
        tick();
        send_addr(2'd0, 12'h400);             // CONNECTED cycle 1
        check("tmo_flag_clear", 32'(rr_tflag), 32'h0);
        repeat (7) tick();                    // CONNECTED cycle 8
        check("tmo_ack_cycle8", 32'(rr_ack), 32'b0001);
        tick();                               // forced CLEAN
        check("tmo_ack_dropped", 32'(rr_ack), 32'h0);
        check("tmo_flag_set", 32'(rr_tflag), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised successor to the two-master/four-slave serial-bus arbiter.
- Supports NUM_MASTERS masters, NUM_SLAVES slaves, a configurable serial address width, and fixed-priority or round-robin arbitration.
- Tracks split transactions per master and per slave, so several masters can hold pending splits at once.
- Sits between master ports and slave/bus-bridge ports on the system bus; routes serial handshake signals for the current bus owner.

Parameters:
- NUM_MASTERS, 2, number of masters (2..8).
- NUM_SLAVES, 4, number of slaves (2..8); slave NUM_SLAVES-1 is the bus bridge by convention.
- ADDR_BITS, 12, serial address length in bits, sent MSB first.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 255, maximum CONNECTED tenure; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- m_breq  in  NUM_MASTERS  bus request per master.
- m_bgrant  out  NUM_MASTERS  one-hot grant.
- m_mode  in  NUM_MASTERS  1 = write, 0 = read.
- m_wr_bus  in  NUM_MASTERS  serial master-to-slave data/address.
- m_rd_bus  out  NUM_MASTERS  serial slave-to-master data.
- m_master_valid  in  NUM_MASTERS  master data valid.
- m_slave_ready  out  NUM_MASTERS  slave ready (or arbiter ready during ADDR).
- m_master_ready  in  NUM_MASTERS  master ready for read data.
- m_slave_valid  out  NUM_MASTERS  slave read data valid.
- m_ack  out  NUM_MASTERS  address accepted.
- m_split  out  NUM_MASTERS  master's transaction currently split.
- s_mode, s_wr_bus, s_master_valid, s_master_ready  out  NUM_SLAVES  per-slave copies of the owner's signals.
- s_rd_bus, s_slave_ready, s_slave_valid  in  NUM_SLAVES  slave responses.
- s_split  in  NUM_SLAVES  slave is holding a split transaction.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; owner, addr, count, rr_ptr and split_pend all cleared to 0.
  - Every output is 0, including m_bgrant.
  - Reset mid-transaction drops all outputs immediately, with no clean-up cycle.
- States: IDLE, GRANT, ADDR, DECODE, CONNECTED, SPLIT, CLEAN.
- Routing:
  - Unselected masters and unselected slaves see 0 on every output.
  - Slave outputs are driven only in CONNECTED, toward the decoded slave.
  - m_bgrant[owner] = 1 in GRANT, ADDR, DECODE and CONNECTED.
- IDLE:
  - Split resume first: if any master i has split_pend[i] = 1 and s_split[split_slv[i]] = 0, it takes priority. The lowest such i becomes owner, its stored slave is restored, and the next state is CONNECTED. split_pend[i] is cleared on the transition.
  - Otherwise, eligible requests are m_breq & ~split_pend.
  - Picker: fixed priority, or round-robin starting at rr_ptr+1.
  - A winner is latched into owner; next state is GRANT.
- GRANT:
  - breq dropped → IDLE.
  - m_master_valid → ADDR (the first address bit is sampled in ADDR).
- ADDR:
  - m_slave_ready[owner] = 1.
  - Each cycle with master_valid = 1, m_wr_bus is shifted into addr and count increments.
  - After ADDR_BITS bits → DECODE.
  - breq dropped at any point → CLEAN.
- DECODE (1 cycle):
  - sel = addr[ADDR_BITS-1 -: $clog2(NUM_SLAVES)].
  - sel < NUM_SLAVES → ack is registered to 1, next state CONNECTED.
  - Otherwise ack = 0, next state CLEAN (NACK). The master samples m_ack in the first CONNECTED or CLEAN cycle.
- CONNECTED:
  - m_ack[owner] = 1.
  - breq drop → CLEAN. This takes precedence over a simultaneous s_split rise.
  - s_split[sel] = 1 → SPLIT.
- SPLIT (1 cycle):
  - split_pend[owner] ← 1 and split_slv[owner] ← sel.
  - Grant is removed; next state IDLE.
- CLEAN (1 cycle): clears addr and count; rr_ptr ← owner; next state IDLE.
- m_split[i] = split_pend[i] & s_split[split_slv[i]].
- Minimum request-to-grant latency: 1 cycle (IDLE→GRANT).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter runs in CONNECTED.
  - When it reaches TIMEOUT_CYCLES with breq still high, the arbiter forces CLEAN.
  - m_ack drops, and a sticky timeout_flag output (1 bit, cleared by reset) is set.
- Undefined: no counter, no timeout_flag port; tenure is unbounded.

Decomposition:
- Package bus_arb_pkg holds:
  - the arb_state_t enum;
  - ARB_FIXED and ARB_RR constants;
  - the function sel_width(n) = $clog2(n).
- Sub-module rr_picker (parameters N and MODE):
  - inputs req[N] and ptr;
  - outputs a one-hot gnt and an index;
  - purely combinational; the pointer register stays in the parent.

Test Plan:
- Single request: NUM_MASTERS = 4; master 2 requests and sends address 0x400 (sel = 1).
  - m_bgrant = 0100 one cycle after breq.
  - m_ack[2] = 1 after 12 address bits plus the DECODE cycle.
  - s_master_valid[1] follows m_master_valid[2].
- Round-robin: ARB_MODE = 1; masters 0, 1 and 3 request continuously, each doing a one-transaction tenure.
  - Grant order is 0, 1, 3, 0.
  - With ARB_MODE = 0 the order is 0, 0, 0.
- Invalid address: NUM_SLAVES = 5; address top 3 bits = 3'b110.
  - m_ack stays 0; state goes to CLEAN then IDLE; no s_master_valid is ever asserted.
- Split with concurrent requests:
  - Master 0 is split by slave 2 (m_split[0] = 1), then master 1 is granted and completes.
  - When s_split[2] falls while master 3 is requesting, master 0 is re-granted first, directly into CONNECTED.
- Simultaneous events:
  - breq drop and s_split rise in the same CONNECTED cycle → CLEAN; split_pend stays 0.
  - rstn low in ADDR → all outputs 0 in the same cycle.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and breq held high: forced CLEAN after 8 CONNECTED cycles; timeout_flag = 1.
